// File: rtl/trap_ret_if.sv
// trap_ret_if: MRET sequencer bus, pipeline/CSR-side signals grouped for trap_ret
interface trap_ret_if #(parameter int CNT_W = 16);
  logic             mret_i;
  logic             trap_in_i;
  logic [31:0]      pc_n_i;
  logic [31:0]      csr_rdata_i;
  logic [31:0]      csr_wdata_o;
  logic             csr_we_o;
  logic [11:0]      csr_addr_o;
  logic [31:0]      pc_n_o;
  logic             ret_jump_o;
  logic             ret_busy_o;
  logic [CNT_W-1:0] ret_cnt_o;
  modport master (
    output mret_i, trap_in_i, pc_n_i, csr_rdata_i,
    input  csr_wdata_o, csr_we_o, csr_addr_o, pc_n_o, ret_jump_o, ret_busy_o, ret_cnt_o
  );
  modport slave (
    input  mret_i, trap_in_i, pc_n_i, csr_rdata_i,
    output csr_wdata_o, csr_we_o, csr_addr_o, pc_n_o, ret_jump_o, ret_busy_o, ret_cnt_o
  );
endinterface

// File: rtl/trap_ret.sv
// trap_ret: MRET sequencer restoring mstatus, reading mepc and redirecting the PC
module trap_ret #(
  parameter int CNT_W = 16
) (
  input  logic      clk,
  input  logic      rst,
  trap_ret_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WTRP, RMST, RMEP, JMPC} state_t;
  state_t           state, state_n;
  logic [31:0]      ret_pc_r;
  logic [CNT_W-1:0] ret_cnt_r;
  logic             in_rmst, in_rmep, in_jmpc, active;
  logic [31:0]      mstatus_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      ret_pc_r  <= '0;
      ret_cnt_r <= '0;
    end else begin
      state <= state_n;
      if (in_rmep) ret_pc_r <= {bus.csr_rdata_i[31:2], 2'b00};
      if (in_jmpc) ret_cnt_r <= ret_cnt_r + 1'b1;
    end
  // Mid-sequence input changes are ignored; illegal encodings fall back to IDLE
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = bus.mret_i ? (bus.trap_in_i ? WTRP : RMST) : IDLE;
      WTRP:    state_n = bus.trap_in_i ? WTRP : RMST;
      RMST:    state_n = RMEP;
      RMEP:    state_n = JMPC;
      JMPC:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    in_rmst   = state == RMST;
    in_rmep   = state == RMEP;
    in_jmpc   = state == JMPC;
    active    = in_rmst || in_rmep || in_jmpc || state == WTRP;
    // MIE <= MPIE, MPIE <= 1, MPP <= M
    mstatus_n = {bus.csr_rdata_i[31:13], 2'b11, bus.csr_rdata_i[10:8], 1'b1,
                 bus.csr_rdata_i[6:4], bus.csr_rdata_i[7], bus.csr_rdata_i[2:0]};
    bus.csr_we_o    = in_rmst;
    bus.csr_addr_o  = in_rmst ? 12'h300 : in_rmep ? 12'h341 : 12'h000;
    bus.csr_wdata_o = in_rmst ? mstatus_n : 32'h0;
    bus.ret_jump_o  = in_jmpc;
    bus.pc_n_o      = in_jmpc ? ret_pc_r : bus.pc_n_i;
    bus.ret_busy_o  = active || bus.mret_i;
    bus.ret_cnt_o   = ret_cnt_r;
  end
endmodule

// File: tb/tb_trap_ret.sv
// tb_trap_ret: randomized self-checking bench for the MRET sequencer
module tb_trap_ret;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] mstatus, mepc;
  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  trap_ret_if #(.CNT_W(4)) bus();
  trap_ret #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always_comb
    bus.csr_rdata_i = bus.csr_addr_o == 12'h300 ? mstatus :
                      bus.csr_addr_o == 12'h341 ? mepc : 32'hdeadbeef;
  function automatic logic [31:0] mret_mstatus(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    r[3] = v[7];
    r[7] = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction
  task automatic do_ret(input logic [31:0] ms, input logic [31:0] me, input int k, input string nm);
    mstatus = ms;
    mepc = me;
    bus.pc_n_i = $urandom;
    bus.mret_i = 1'b1;
    bus.trap_in_i = k > 0;
    #1 n_cmp++;
    if ({bus.ret_busy_o, bus.ret_jump_o, bus.csr_we_o} !== 3'b100) begin
      n_err++; $display("FAIL %s idle_req got %b want 100", nm, {bus.ret_busy_o, bus.ret_jump_o, bus.csr_we_o});
    end
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.ret_busy_o, bus.csr_we_o, bus.ret_jump_o, bus.csr_addr_o, bus.pc_n_o} !== {3'b100, 12'h0, bus.pc_n_i}) begin
        n_err++; $display("FAIL %s wtrp[%0d] busy/we/jmp=%b addr=%h pc=%h want 100/000/%h", nm, i,
          {bus.ret_busy_o, bus.csr_we_o, bus.ret_jump_o}, bus.csr_addr_o, bus.pc_n_o, bus.pc_n_i);
      end
      bus.trap_in_i = i < k - 1;
      bus.mret_i = 1'($urandom);
      bus.pc_n_i = $urandom;
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.csr_we_o, bus.csr_addr_o, bus.csr_wdata_o, bus.ret_jump_o, bus.ret_busy_o} !== {1'b1, 12'h300, mret_mstatus(ms), 2'b01}) begin
      n_err++; $display("FAIL %s rmst we=%b addr=%h wdata=%h jmp=%b busy=%b want 1/300/%h/0/1", nm,
        bus.csr_we_o, bus.csr_addr_o, bus.csr_wdata_o, bus.ret_jump_o, bus.ret_busy_o, mret_mstatus(ms));
    end
    bus.mret_i = 1'($urandom);
    bus.trap_in_i = 1'($urandom);
    bus.pc_n_i = $urandom;
    @(negedge clk);
    n_cmp++;
    if ({bus.csr_we_o, bus.csr_addr_o, bus.csr_wdata_o, bus.ret_jump_o, bus.ret_busy_o} !== {1'b0, 12'h341, 32'h0, 2'b01}) begin
      n_err++; $display("FAIL %s rmep we=%b addr=%h wdata=%h jmp=%b busy=%b want 0/341/0/0/1", nm,
        bus.csr_we_o, bus.csr_addr_o, bus.csr_wdata_o, bus.ret_jump_o, bus.ret_busy_o);
    end
    bus.mret_i = 1'($urandom);
    bus.trap_in_i = 1'($urandom);
    bus.pc_n_i = $urandom;
    @(negedge clk);
    n_cmp++;
    if ({bus.ret_jump_o, bus.pc_n_o, bus.csr_we_o, bus.csr_addr_o, bus.ret_busy_o, bus.ret_cnt_o} !== {1'b1, me & ~32'h3, 13'h0, 1'b1, 4'(exp_cnt)}) begin
      n_err++; $display("FAIL %s jmpc jmp=%b pc=%h we=%b addr=%h busy=%b cnt=%0d want 1/%h/0/000/1/%0d", nm,
        bus.ret_jump_o, bus.pc_n_o, bus.csr_we_o, bus.csr_addr_o, bus.ret_busy_o, bus.ret_cnt_o, me & ~32'h3, exp_cnt);
    end
    bus.mret_i = 1'b0;
    bus.trap_in_i = 1'b0;
    exp_cnt = (exp_cnt + 1) % 16;
    @(negedge clk);
    n_cmp++;
    if ({bus.ret_jump_o, bus.ret_busy_o, bus.csr_we_o, bus.ret_cnt_o} !== {3'b000, 4'(exp_cnt)}) begin
      n_err++; $display("FAIL %s done jmp/busy/we=%b cnt=%0d want 000/%0d", nm,
        {bus.ret_jump_o, bus.ret_busy_o, bus.csr_we_o}, bus.ret_cnt_o, exp_cnt);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    mstatus = 32'h0;
    mepc = 32'h0;
    bus.trap_in_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.mret_i = 1'($urandom);
      bus.pc_n_i = $urandom;
      @(negedge clk);
      n_cmp++;
      if ({bus.pc_n_o, bus.ret_jump_o, bus.csr_we_o, bus.csr_addr_o, bus.csr_wdata_o, bus.ret_busy_o, bus.ret_cnt_o} !==
          {bus.pc_n_i, 46'h0, bus.mret_i, 4'h0}) begin
        n_err++; $display("FAIL reset[%0d] pc=%h jmp=%b we=%b addr=%h wd=%h busy=%b cnt=%0d want pc=%h busy=%b rest 0", i,
          bus.pc_n_o, bus.ret_jump_o, bus.csr_we_o, bus.csr_addr_o, bus.csr_wdata_o, bus.ret_busy_o, bus.ret_cnt_o, bus.pc_n_i, bus.mret_i);
      end
    end
    bus.mret_i = 1'b0;
    rst = 1'b0;
    exp_cnt = 0;
  endtask
  task automatic test_idle_passthrough();
    bus.mret_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.pc_n_i = $urandom;
      bus.trap_in_i = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({bus.pc_n_o, bus.csr_we_o, bus.ret_busy_o, bus.ret_jump_o, bus.csr_addr_o, bus.csr_wdata_o} !== {bus.pc_n_i, 47'h0}) begin
        n_err++; $display("FAIL idle[%0d] pc=%h we=%b busy=%b jmp=%b addr=%h wd=%h want pc=%h rest 0", i,
          bus.pc_n_o, bus.csr_we_o, bus.ret_busy_o, bus.ret_jump_o, bus.csr_addr_o, bus.csr_wdata_o, bus.pc_n_i);
      end
    end
    bus.trap_in_i = 1'b0;
  endtask
  task automatic test_basic();
    do_ret(32'h00000080, 32'h00001236, 0, "basic");
    n_cmp++;
    if (mret_mstatus(32'h80) !== 32'h00001888) begin
      n_err++; $display("FAIL basic_model got %h want 00001888", mret_mstatus(32'h80));
    end
  endtask
  task automatic test_mpie0();
    do_ret(32'h00000008, 32'h00004000, 0, "mpie0");
  endtask
  task automatic test_trap_collision();
    do_ret(32'hffff_e777, 32'h8000_0003, 5, "trap");
  endtask
  task automatic test_random();
    for (int i = 0; i < 8; i++) do_ret($urandom, $urandom, int'($urandom_range(0, 3)), "rand");
  endtask
  task automatic test_mid_reset();
    mstatus = 32'h80;
    mepc = 32'h2000;
    bus.mret_i = 1'b1;
    bus.trap_in_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.csr_addr_o !== 12'h341) begin
      n_err++; $display("FAIL midrst_pre addr=%h want 341", bus.csr_addr_o);
    end
    bus.mret_i = 1'b0;
    rst = 1'b1;
    exp_cnt = 0;
    #1 n_cmp++;
    if ({bus.csr_we_o, bus.csr_addr_o, bus.csr_wdata_o, bus.ret_jump_o, bus.ret_busy_o, bus.ret_cnt_o, bus.pc_n_o} !== {47'h0, 4'h0, bus.pc_n_i}) begin
      n_err++; $display("FAIL midrst we=%b addr=%h wd=%h jmp=%b busy=%b cnt=%0d pc=%h want 0s pc=%h",
        bus.csr_we_o, bus.csr_addr_o, bus.csr_wdata_o, bus.ret_jump_o, bus.ret_busy_o, bus.ret_cnt_o, bus.pc_n_o, bus.pc_n_i);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.ret_jump_o, bus.csr_we_o, bus.ret_busy_o, bus.ret_cnt_o} !== 7'h0) begin
        n_err++; $display("FAIL midrst_after[%0d] jmp=%b we=%b busy=%b cnt=%0d want 0", i,
          bus.ret_jump_o, bus.csr_we_o, bus.ret_busy_o, bus.ret_cnt_o);
      end
    end
  endtask
  task automatic test_back_to_back_wrap();
    for (int i = 0; i < 16; i++) do_ret($urandom, $urandom, 0, "wrap");
    n_cmp++;
    if (bus.ret_cnt_o !== 4'h0) begin
      n_err++; $display("FAIL wrap_end cnt=%0d want 0", bus.ret_cnt_o);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_idle_passthrough();
    test_basic();
    test_mpie0();
    test_trap_collision();
    test_random();
    test_mid_reset();
    test_back_to_back_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
